dmem_mmio_responder: RTL

- Responder end of the CPU data-memory bus: takes Addr_out/Data_out/MemRW-style requests from the core and answers with read data.
- Decodes each request to either the RAM block (pass-through) or a small MMIO register file: LED register, 64-bit cycle counter, compare timer with IRQ, and a console TX FIFO drained by a valid/ready consumer.
- Sits between the CPU data port and the RAM in the SoC top.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/mmio_con_fifo.sv | 77 +++++++
 rtl/dmem_mmio_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory MMIO responder.
// Holds the MMIO register offsets (addr_in[7:0]) and the bit positions inside
// the TMR_CTRL and CON_STAT registers, so the RTL and any software-side model
// agree on one register map.
package mmio_pkg;

   // Register offsets within the MMIO window
   localparam logic [7:0] OFF_LED      = 8'h00;
   localparam logic [7:0] OFF_CYC_LO   = 8'h04;
   localparam logic [7:0] OFF_CYC_HI   = 8'h08;
   localparam logic [7:0] OFF_TMR_CMP  = 8'h0C;
   localparam logic [7:0] OFF_TMR_CTRL = 8'h10;
   localparam logic [7:0] OFF_CON_TX   = 8'h14;
   localparam logic [7:0] OFF_CON_STAT = 8'h18;

   // TMR_CTRL bit positions
   localparam int TMR_EN_BIT     = 0;
   localparam int TMR_IRQ_EN_BIT = 1;
   localparam int TMR_FLAG_BIT   = 2;

   // CON_STAT bit positions
   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_CNT_LSB   = 2;
   localparam int STAT_CNT_MSB   = 6;
   localparam int STAT_OVF_BIT   = 7;

endpackage

// File: rtl/mmio_con_fifo.sv
// Console transmit FIFO: a small byte queue between CPU stores and the
// valid/ready console consumer.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the queue)
//   push, din      enqueue din; ignored when full unless a pop happens too
//   pop            dequeue head; ignored when empty
//   head           current head byte, forced to 0 while empty
//   full, empty    occupancy flags
//   count          number of stored bytes (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module mmio_con_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full  = (cnt == CNT_FULL);
   assign empty = (cnt == '0);
   assign count = cnt;

   // A pop frees the head slot at the same edge, so a full FIFO may still
   // accept a push when it is being drained in that cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is shown only while something is queued; no bypass from din.
   assign head = empty ? 8'h00 : mem[rd_ptr];

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Responder end of the CPU data-memory bus. Each request is steered either to
// the external RAM (pass-through) or to a small MMIO register file holding an
// LED register, a 64-bit cycle counter with a high-word snapshot, a compare
// timer with IRQ, and a console TX FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   addr_in, wdata_in     CPU byte address (word aligned) and store data
//   we_in, re_in          store strobe; load strobe (gates read side effects)
//   rdata_out             combinational load data
//   ram_addr/we/wdata     RAM request; ram_rdata is the RAM's read data
//   led_out               LED register
//   con_data, con_valid   console FIFO head and not-empty
//   con_ready             consumer takes the head on a posedge while valid
//   irq_out               timer flag gated by irq_en
// Optional build macro MMIO_TRACE_EN: prints a line for every MMIO write, every
// console pop and every dropped console push (simulation only).
module dmem_mmio_responder
   import mmio_pkg::*;
#(
   parameter int         CON_DEPTH     = 4,
   parameter int         LED_W         = 16,
   parameter logic [3:0] MMIO_BASE_NIB = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr_in,
   input  logic [31:0]      wdata_in,
   input  logic             we_in,
   input  logic             re_in,
   output logic [31:0]      rdata_out,
   output logic [9:0]       ram_addr,
   output logic             ram_we,
   output logic [31:0]      ram_wdata,
   input  logic [31:0]      ram_rdata,
   output logic [LED_W-1:0] led_out,
   output logic [7:0]       con_data,
   output logic             con_valid,
   input  logic             con_ready,
   output logic             irq_out
);

   logic                       mmio_sel;
   logic [7:0]                 off;
   logic                       mmio_wr;
   logic [31:0]                mmio_rdata;
   logic [LED_W-1:0]           led;
   logic [63:0]                cyc;
   logic [31:0]                cyc_hi_snap;
   logic [31:0]                tmr_cmp;
   logic [31:0]                tmr_cnt;
   logic                       tmr_en;
   logic                       tmr_irq_en;
   logic                       tmr_flag;
   logic                       tmr_fire;
   logic                       ctrl_wr;
   logic                       con_push;
   logic                       con_pop;
   logic                       con_ovf;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [$clog2(CON_DEPTH):0] fifo_count;
   logic                       unused_addr_bits;

   // Only the window nibble, the RAM word index and the register offset matter.
   assign unused_addr_bits = ^{addr_in[27:12], addr_in[1:0]};

   assign mmio_sel  = (addr_in[31:28] == MMIO_BASE_NIB);
   assign off       = addr_in[7:0];
   assign mmio_wr   = we_in & mmio_sel;
   assign ctrl_wr   = mmio_wr & (off == OFF_TMR_CTRL);

   assign ram_addr  = addr_in[11:2];
   assign ram_we    = we_in & ~mmio_sel;
   assign ram_wdata = wdata_in;
   assign rdata_out = mmio_sel ? mmio_rdata : ram_rdata;

   assign led_out   = led;
   assign irq_out   = tmr_flag & tmr_irq_en;

   // A compare of zero never fires; otherwise the period is tmr_cmp cycles.
   assign tmr_fire  = tmr_en & (tmr_cmp != '0) & (tmr_cnt == tmr_cmp - 32'd1);

   assign con_push  = mmio_wr & (off == OFF_CON_TX);
   assign con_pop   = con_valid & con_ready;
   assign con_valid = ~fifo_empty;

   // Register read mux; unmapped and write-only offsets read as zero.
   always_comb begin
      mmio_rdata = '0;
      case (off)
         OFF_LED:      mmio_rdata[LED_W-1:0] = led;
         OFF_CYC_LO:   mmio_rdata = cyc[31:0];
         OFF_CYC_HI:   mmio_rdata = cyc_hi_snap;
         OFF_TMR_CMP:  mmio_rdata = tmr_cmp;
         OFF_TMR_CTRL: begin
            mmio_rdata[TMR_EN_BIT]     = tmr_en;
            mmio_rdata[TMR_IRQ_EN_BIT] = tmr_irq_en;
            mmio_rdata[TMR_FLAG_BIT]   = tmr_flag;
         end
         OFF_CON_STAT: begin
            mmio_rdata[STAT_FULL_BIT]                = fifo_full;
            mmio_rdata[STAT_EMPTY_BIT]               = fifo_empty;
            mmio_rdata[STAT_CNT_MSB:STAT_CNT_LSB]    = 5'(fifo_count);
            mmio_rdata[STAT_OVF_BIT]                 = con_ovf;
         end
         default: mmio_rdata = '0;
      endcase
   end

   // LED register and the free-running cycle counter. Reading CYC_LO freezes
   // the matching high word so a following CYC_HI read is coherent even if a
   // carry into the high word happens in between.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led         <= '0;
         cyc         <= '0;
         cyc_hi_snap <= '0;
      end else begin
         cyc <= cyc + 64'd1;
         if (mmio_wr && off == OFF_LED) begin
            led <= wdata_in[LED_W-1:0];
         end
         if (mmio_sel && re_in && off == OFF_CYC_LO) begin
            cyc_hi_snap <= cyc[63:32];
         end
      end
   end

   // Compare timer. Rewriting the compare value restarts the count. A firing
   // edge beats a same-cycle write-one-to-clear of the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_cmp    <= '0;
         tmr_cnt    <= '0;
         tmr_en     <= 1'b0;
         tmr_irq_en <= 1'b0;
         tmr_flag   <= 1'b0;
      end else begin
         if (mmio_wr && off == OFF_TMR_CMP) begin
            tmr_cmp <= wdata_in;
            tmr_cnt <= '0;
         end else if (tmr_en && tmr_cmp != '0) begin
            tmr_cnt <= tmr_fire ? '0 : tmr_cnt + 32'd1;
         end
         if (ctrl_wr) begin
            tmr_en     <= wdata_in[TMR_EN_BIT];
            tmr_irq_en <= wdata_in[TMR_IRQ_EN_BIT];
         end
         if (tmr_fire) begin
            tmr_flag <= 1'b1;
         end else if (ctrl_wr && wdata_in[TMR_FLAG_BIT]) begin
            tmr_flag <= 1'b0;
         end
      end
   end

   // Sticky overflow: set when a push is dropped because the FIFO is full and
   // nothing leaves in the same cycle; cleared by writing 1 to its status bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         con_ovf <= 1'b0;
      end else if (con_push && fifo_full && !con_pop) begin
         con_ovf <= 1'b1;
      end else if (mmio_wr && off == OFF_CON_STAT && wdata_in[STAT_OVF_BIT]) begin
         con_ovf <= 1'b0;
      end
   end

   mmio_con_fifo #(
      .DEPTH (CON_DEPTH)
   ) u_con_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (con_push),
      .din   (wdata_in[7:0]),
      .pop   (con_pop),
      .head  (con_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef MMIO_TRACE_EN
   // Bus activity trace for simulation debugging.
   always @(posedge clk) begin
      if (!rst) begin
         if (mmio_wr) begin
            $display("[mmio] cyc=%0d wr off=%02h data=%08h", cyc, off, wdata_in);
         end
         if (con_pop) begin
            $display("[mmio] cyc=%0d pop off=%02h data=%02h", cyc, OFF_CON_TX, con_data);
         end
         if (con_push && fifo_full && !con_pop) begin
            $display("[mmio] con overflow");
         end
      end
   end
`endif

endmodule
